// File: rtl/hazard_controller_pkg.sv
// Shared types for the hazard controller: forward-select encoding and FSM states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package hazard_controller_pkg;

   localparam int          REG_W   = 5;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Operand source selection for the EXE stage.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } hz_state_t;

   // True when a destination register is real (not x0) and names the source register.
   function automatic logic reg_match(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
      return (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/hazard_controller_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register for multi-cycle ops.
// Latency: set/clear take effect at the next clk edge; sb_vec is a plain register.
// Backpressure: none; x0 is never tracked, and a set wins over a same-cycle clear.
module reg_scoreboard
   import hazard_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_idx,
   output logic [31:0]      sb_vec
);

   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   // Decode set/clear requests into one-hot masks, dropping x0.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_idx != '0)) set_mask[set_idx] = 1'b1;
      if (clr_en && (clr_idx != '0)) clr_mask[clr_idx] = 1'b1;
   end

   // Clear first, then OR in the set so a same-cycle set on the same bit survives.
   always_ff @(posedge clk) begin
      if (rst) sb_vec <= '0;
      else     sb_vec <= (sb_vec & ~clr_mask) | set_mask;
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stalls, flushes, operand forwarding and a stall counter.
// Latency: stall/flush/forward outputs are combinational from the current inputs and state.
// Backpressure: holds IF/ID and bubbles EXE on hazards; FORWARDING_EN selects the bypass build.
module hazard_controller
   import hazard_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  rs1_d,
   input  logic [4:0]  rs2_d,
   input  logic [4:0]  a1_e,
   input  logic [4:0]  a2_e,
   input  logic [4:0]  rd_e,
   input  logic        reg_write_e,
   input  logic        mem_load_e,
   input  logic [4:0]  rd_m,
   input  logic        reg_write_m,
   input  logic [4:0]  rd_w,
   input  logic        reg_write_w,
   input  logic        branch_taken_e,
   input  logic        muldiv_start_e,
   input  logic        muldiv_done,
   input  logic [4:0]  muldiv_rd,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_id,
   output logic        flush_exe,
   output logic [1:0]  fwd_a_e,
   output logic [1:0]  fwd_b_e,
   output logic [15:0] perf_stall_cnt
);

   logic [31:0] sb_vec;
   hz_state_t   state;
   logic [15:0] stall_cnt;
   logic        sb_hit;
   logic        lu_hit;
   logic        raw_hit;
   logic        hazard;
   logic        stall_c;
   logic        flush_id_c;
   logic        flush_exe_c;
   fwd_sel_t    fwd_a;
   fwd_sel_t    fwd_b;

   reg_scoreboard u_sb (
      .clk     (clk),
      .rst     (rst),
      .set_en  (muldiv_start_e),
      .set_idx (rd_e),
      .clr_en  (muldiv_done),
      .clr_idx (muldiv_rd),
      .sb_vec  (sb_vec)
   );

   // Hazard detection. The only destination visible here is rd_e, so the WAW check
   // looks at a writing EXE instruction targeting a register still owned by a multi-cycle op.
   always_comb begin
      sb_hit = id_valid && (((rs1_d != '0) && sb_vec[rs1_d]) ||
                            ((rs2_d != '0) && sb_vec[rs2_d]) ||
                            (reg_write_e && (rd_e != '0) && sb_vec[rd_e]));
      lu_hit = id_valid && mem_load_e && (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));
`ifdef FORWARDING_EN
      raw_hit = 1'b0;
`else
      // No bypass from EXE/MEM: any in-flight writer of an ID source must drain first.
      raw_hit = id_valid &&
                ((reg_write_e && (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d))) ||
                 (reg_write_m && (reg_match(rd_m, rs1_d) || reg_match(rd_m, rs2_d))));
`endif
      // ID holds a squashed slot right after a redirect, so nothing there can hazard.
      hazard = (state != ST_FLUSH) && (sb_hit || lu_hit || raw_hit);
   end

   // Redirect outranks every stall; the stall sources all produce the same response.
   always_comb begin
      stall_c     = 1'b0;
      flush_id_c  = 1'b0;
      flush_exe_c = 1'b0;
      if (branch_taken_e) begin
         flush_id_c  = 1'b1;
         flush_exe_c = 1'b1;
      end else if (hazard) begin
         stall_c     = 1'b1;
         flush_exe_c = 1'b1;
      end
   end

   // Operand forwarding for the EXE sources; MEM is the younger result and wins over WB.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
`ifdef FORWARDING_EN
      if (reg_write_m && reg_match(rd_m, a1_e))      fwd_a = FWD_MEM;
      else if (reg_write_w && reg_match(rd_w, a1_e)) fwd_a = FWD_WB;
      if (reg_write_m && reg_match(rd_m, a2_e))      fwd_b = FWD_MEM;
      else if (reg_write_w && reg_match(rd_w, a2_e)) fwd_b = FWD_WB;
`endif
   end

`ifndef FORWARDING_EN
   // EXE operand names and WB info only matter to the bypass network.
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{a1_e, a2_e, rd_w, reg_write_w};
`endif

   // Controller state: remembers a redirect so the next ID slot is treated as dead.
   always_ff @(posedge clk) begin
      if (rst)                 state <= ST_RUN;
      else if (branch_taken_e) state <= ST_FLUSH;
      else if (stall_c)        state <= ST_STALL;
      else                     state <= ST_RUN;
   end

   // Stall-cycle counter, saturating so long runs never wrap to a misleading small value.
   always_ff @(posedge clk) begin
      if (rst)                                stall_cnt <= '0;
      else if (stall_c && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 16'd1;
   end

   // All outputs are forced low while reset is held.
   assign stall_if       = ~rst & stall_c;
   assign stall_id       = ~rst & stall_c;
   assign flush_id       = ~rst & flush_id_c;
   assign flush_exe      = ~rst & flush_exe_c;
   assign fwd_a_e        = rst ? 2'b00 : fwd_a;
   assign fwd_b_e        = rst ? 2'b00 : fwd_b;
   assign perf_stall_cnt = rst ? 16'd0 : stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table, directed corner sequences, random vs model.
// Latency: checks combinational outputs 1ns after the falling edge, counter after the rising edge.
// Backpressure: n/a.
module tb_hazard_controller;

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid, reg_write_e, mem_load_e, reg_write_m, reg_write_w;
   logic        branch_taken_e, muldiv_start_e, muldiv_done;
   logic [4:0]  rs1_d, rs2_d, a1_e, a2_e, rd_e, rd_m, rd_w, muldiv_rd;
   logic        stall_if, stall_id, flush_id, flush_exe;
   logic [1:0]  fwd_a_e, fwd_b_e;
   logic [15:0] perf_stall_cnt;

   always #5 clk = ~clk;

   hazard_controller dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .a1_e(a1_e), .a2_e(a2_e), .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_load_e(mem_load_e),
      .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
      .branch_taken_e(branch_taken_e), .muldiv_start_e(muldiv_start_e),
      .muldiv_done(muldiv_done), .muldiv_rd(muldiv_rd),
      .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_exe(flush_exe),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .perf_stall_cnt(perf_stall_cnt)
   );

   typedef struct {
      logic       id_valid;
      logic [4:0] rs1_d, rs2_d, a1_e, a2_e, rd_e;
      logic       reg_write_e, mem_load_e;
      logic [4:0] rd_m;
      logic       reg_write_m;
      logic [4:0] rd_w;
      logic       reg_write_w, branch_taken_e, muldiv_start_e, muldiv_done;
      logic [4:0] muldiv_rd;
   } inp_t;

   typedef struct {
      logic        stall_if, stall_id, flush_id, flush_exe;
      logic [1:0]  fa, fb;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      inp_t       in;
      logic [3:0] ctl;   // {stall_if, stall_id, flush_id, flush_exe}
      logic [1:0] fa, fb;
      string      name;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Reference model state, expressed in the spec's own terms.
   bit m_pending[32];   // register has an outstanding multi-cycle writeback
   bit m_slot_dead;     // previous cycle redirected, so ID holds a squashed slot
   int m_stalls;        // stall cycles seen since reset, saturating at 65535

   logic s_stall_if, s_stall_id, s_flush_id, s_flush_exe;

   vec_t tbl[$];

   function automatic inp_t idle();
      inp_t v;
      v = '{default: '0};
      return v;
   endfunction

   function automatic logic [1:0] fwd_of(input inp_t v, input logic [4:0] src);
      if (!FWD) return 2'b00;
      if (v.reg_write_m && v.rd_m != 0 && v.rd_m == src) return 2'b10;
      if (v.reg_write_w && v.rd_w != 0 && v.rd_w == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit writes(input logic en, input logic [4:0] rd, input logic [4:0] src);
      return en && rd != 0 && rd == src;
   endfunction

   function automatic exp_t model_out(input inp_t v, input bit r);
      exp_t e;
      bit   sb, lu, raw, haz;
      e = '{default: '0};
      if (r) return e;
      sb  = v.id_valid && ((v.rs1_d != 0 && m_pending[v.rs1_d]) || (v.rs2_d != 0 && m_pending[v.rs2_d]) ||
                           (v.reg_write_e && v.rd_e != 0 && m_pending[v.rd_e]));
      lu  = v.id_valid && writes(v.mem_load_e, v.rd_e, v.rs1_d) | writes(v.mem_load_e, v.rd_e, v.rs2_d);
      raw = !FWD && v.id_valid &&
            (writes(v.reg_write_e, v.rd_e, v.rs1_d) || writes(v.reg_write_e, v.rd_e, v.rs2_d) ||
             writes(v.reg_write_m, v.rd_m, v.rs1_d) || writes(v.reg_write_m, v.rd_m, v.rs2_d));
      haz = !m_slot_dead && (sb || lu || raw);
      if (v.branch_taken_e) begin
         e.flush_id = 1'b1; e.flush_exe = 1'b1;
      end else if (haz) begin
         e.stall_if = 1'b1; e.stall_id = 1'b1; e.flush_exe = 1'b1;
      end
      e.fa  = fwd_of(v, v.a1_e);
      e.fb  = fwd_of(v, v.a2_e);
      e.cnt = 16'(m_stalls);
      return e;
   endfunction

   task automatic model_edge(input inp_t v, input bit r, input bit stalled);
      if (r) begin
         foreach (m_pending[i]) m_pending[i] = 1'b0;
         m_slot_dead = 1'b0;
         m_stalls    = 0;
      end else begin
         if (v.muldiv_done && v.muldiv_rd != 0) m_pending[v.muldiv_rd] = 1'b0;
         if (v.muldiv_start_e && v.rd_e != 0)   m_pending[v.rd_e]      = 1'b1;
         m_slot_dead = v.branch_taken_e;
         if (stalled && m_stalls < 65535) m_stalls++;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input inp_t v, input bit r);
      rst = r;
      id_valid = v.id_valid; rs1_d = v.rs1_d; rs2_d = v.rs2_d; a1_e = v.a1_e; a2_e = v.a2_e;
      rd_e = v.rd_e; reg_write_e = v.reg_write_e; mem_load_e = v.mem_load_e;
      rd_m = v.rd_m; reg_write_m = v.reg_write_m; rd_w = v.rd_w; reg_write_w = v.reg_write_w;
      branch_taken_e = v.branch_taken_e; muldiv_start_e = v.muldiv_start_e;
      muldiv_done = v.muldiv_done; muldiv_rd = v.muldiv_rd;
   endtask

   // One clock: drive, sample away from the edge, optionally compare to the model, then advance it.
   task automatic cycle(input inp_t v, input bit r, input bit chk);
      exp_t e;
      @(negedge clk);
      drive(v, r);
      #1;
      e = model_out(v, r);
      s_stall_if = stall_if; s_stall_id = stall_id; s_flush_id = flush_id; s_flush_exe = flush_exe;
      if (chk) begin
         check("stall_if", stall_if, e.stall_if);
         check("stall_id", stall_id, e.stall_id);
         check("flush_id", flush_id, e.flush_id);
         check("flush_exe", flush_exe, e.flush_exe);
         check("fwd_a_e", fwd_a_e, e.fa);
         check("fwd_b_e", fwd_b_e, e.fb);
         check("perf_stall_cnt", perf_stall_cnt, e.cnt);
      end
      @(posedge clk);
      model_edge(v, r, e.stall_id);
   endtask

   task automatic add_vec(input string n, input inp_t v, input logic [3:0] ctl,
                          input logic [1:0] fa, input logic [1:0] fb);
      vec_t t;
      t.name = n; t.in = v; t.ctl = ctl; t.fa = fa; t.fb = fb;
      tbl.push_back(t);
   endtask

   inp_t lu5;

   initial begin
      inp_t v;
      drive(idle(), 1'b1);
      lu5 = idle();
      lu5.id_valid = 1; lu5.mem_load_e = 1; lu5.rd_e = 5; lu5.rs1_d = 5;

      // ---- vector table, each applied from a freshly reset controller ----
      add_vec("lu_rs1", lu5, 4'b1101, 2'b00, 2'b00);
      v = lu5; v.rs1_d = 0; v.rs2_d = 5;           add_vec("lu_rs2", v, 4'b1101, 2'b00, 2'b00);
      v = lu5; v.rd_e = 0; v.rs1_d = 0;            add_vec("lu_x0", v, 4'b0000, 2'b00, 2'b00);
      v = lu5; v.id_valid = 0;                     add_vec("lu_noid", v, 4'b0000, 2'b00, 2'b00);
      v = lu5; v.branch_taken_e = 1;               add_vec("br_lu", v, 4'b0011, 2'b00, 2'b00);
      v = idle(); v.branch_taken_e = 1;            add_vec("br_only", v, 4'b0011, 2'b00, 2'b00);
      v = lu5; v.rs1_d = 6;                        add_vec("lu_miss", v, 4'b0000, 2'b00, 2'b00);
      v = idle(); v.reg_write_m = 1; v.rd_m = 3; v.reg_write_w = 1; v.rd_w = 3; v.a1_e = 3;
      add_vec("fwd_mem_prio", v, 4'b0000, FWD ? 2'b10 : 2'b00, 2'b00);
      v = idle(); v.reg_write_w = 1; v.rd_w = 4; v.a2_e = 4;
      add_vec("fwd_wb", v, 4'b0000, 2'b00, FWD ? 2'b01 : 2'b00);
      v = idle(); v.reg_write_m = 1; v.rd_m = 0; v.a1_e = 0;
      add_vec("fwd_x0", v, 4'b0000, 2'b00, 2'b00);
      v = idle(); v.id_valid = 1; v.rs1_d = 8; v.reg_write_m = 1; v.rd_m = 8; v.a1_e = 8;
      add_vec("raw_mem", v, FWD ? 4'b0000 : 4'b1101, FWD ? 2'b10 : 2'b00, 2'b00);
      v = idle(); v.id_valid = 1; v.rs2_d = 4; v.reg_write_w = 1; v.rd_w = 4;
      add_vec("raw_wb", v, 4'b0000, 2'b00, 2'b00);
      v = idle(); v.id_valid = 1; v.rs1_d = 6; v.reg_write_e = 1; v.rd_e = 6;
      add_vec("raw_exe", v, FWD ? 4'b0000 : 4'b1101, 2'b00, 2'b00);

      foreach (tbl[i]) begin
         cycle(lu5, 1'b1, 1'b0);
         @(negedge clk);
         drive(tbl[i].in, 1'b0);
         #1;
         check({"vec_ctl_", tbl[i].name}, {stall_if, stall_id, flush_id, flush_exe}, tbl[i].ctl);
         check({"vec_fa_", tbl[i].name}, fwd_a_e, tbl[i].fa);
         check({"vec_fb_", tbl[i].name}, fwd_b_e, tbl[i].fb);
         @(posedge clk);
         model_edge(tbl[i].in, 1'b0, tbl[i].ctl[2]);
      end

      // ---- outputs held low during reset even with hazardous inputs ----
      v = lu5; v.branch_taken_e = 1; v.reg_write_m = 1; v.rd_m = 2; v.a1_e = 2;
      cycle(v, 1'b1, 1'b1);
      check("rst_outs", {s_stall_if, s_stall_id, s_flush_id, s_flush_exe}, 4'b0000);

      // ---- load-use: one stall cycle, counter reads 1 ----
      cycle(lu5, 1'b0, 1'b1);
      check("lu_stall", {s_stall_if, s_stall_id, s_flush_exe}, 3'b111);
      cycle(idle(), 1'b0, 1'b1);
      check("lu_cnt", perf_stall_cnt, 16'd1);

      // ---- branch beats load-use; next cycle the hazard is ignored, then it stalls ----
      cycle(idle(), 1'b1, 1'b0);
      v = lu5; v.branch_taken_e = 1;
      cycle(v, 1'b0, 1'b1);
      check("br_prio", {s_stall_if, s_stall_id, s_flush_id, s_flush_exe}, 4'b0011);
      cycle(lu5, 1'b0, 1'b1);
      check("flush_ignores", s_stall_id, 1'b0);
      cycle(lu5, 1'b0, 1'b1);
      check("after_flush", s_stall_id, 1'b1);

      // ---- scoreboard: stall until muldiv_done, drops the cycle after the clear ----
      cycle(idle(), 1'b1, 1'b0);
      v = idle(); v.muldiv_start_e = 1; v.rd_e = 7;
      cycle(v, 1'b0, 1'b1);
      v = idle(); v.id_valid = 1; v.rs2_d = 7;
      for (int i = 0; i < 4; i++) begin
         cycle(v, 1'b0, 1'b1);
         check("sb_wait", s_stall_id, 1'b1);
      end
      v.muldiv_done = 1; v.muldiv_rd = 7;
      cycle(v, 1'b0, 1'b1);
      check("sb_clr_cycle", s_stall_id, 1'b1);
      v.muldiv_done = 0;
      cycle(v, 1'b0, 1'b1);
      check("sb_released", s_stall_id, 1'b0);
      // same-cycle set and clear: set wins
      v = idle(); v.muldiv_start_e = 1; v.rd_e = 7; v.muldiv_done = 1; v.muldiv_rd = 7;
      cycle(v, 1'b0, 1'b1);
      v = idle(); v.id_valid = 1; v.rs1_d = 7;
      cycle(v, 1'b0, 1'b1);
      check("sb_set_wins", s_stall_id, 1'b1);

      // ---- saturation, then reset with scoreboard bit 9 pending ----
      cycle(idle(), 1'b1, 1'b0);
      for (int i = 0; i < 70000; i++) cycle(lu5, 1'b0, 1'b0);
      cycle(idle(), 1'b0, 1'b1);
      check("cnt_sat", perf_stall_cnt, 16'hFFFF);
      v = idle(); v.muldiv_start_e = 1; v.rd_e = 9;
      cycle(v, 1'b0, 1'b1);
      v = idle(); v.id_valid = 1; v.rs1_d = 9;
      cycle(v, 1'b0, 1'b1);
      check("sb9_set", s_stall_id, 1'b1);
      cycle(v, 1'b1, 1'b1);
      cycle(v, 1'b0, 1'b1);
      check("sb9_cleared", s_stall_id, 1'b0);
      check("cnt_rst", perf_stall_cnt, 16'd0);
      v = idle(); v.muldiv_done = 1; v.muldiv_rd = 9;
      cycle(v, 1'b0, 1'b1);
      v = idle(); v.id_valid = 1; v.rs2_d = 9;
      cycle(v, 1'b0, 1'b1);
      check("late_done", s_stall_id, 1'b0);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         v.id_valid       = ($urandom_range(0, 3) != 0);
         v.rs1_d          = 5'($urandom_range(0, 7));
         v.rs2_d          = 5'($urandom_range(0, 7));
         v.a1_e           = 5'($urandom_range(0, 7));
         v.a2_e           = 5'($urandom_range(0, 7));
         v.rd_e           = 5'($urandom_range(0, 7));
         v.reg_write_e    = $urandom_range(0, 1) == 1;
         v.mem_load_e     = ($urandom_range(0, 3) == 0);
         v.rd_m           = 5'($urandom_range(0, 7));
         v.reg_write_m    = $urandom_range(0, 1) == 1;
         v.rd_w           = 5'($urandom_range(0, 7));
         v.reg_write_w    = $urandom_range(0, 1) == 1;
         v.branch_taken_e = ($urandom_range(0, 7) == 0);
         v.muldiv_start_e = ($urandom_range(0, 7) == 0);
         v.muldiv_done    = ($urandom_range(0, 5) == 0);
         v.muldiv_rd      = 5'($urandom_range(0, 7));
         cycle(v, $urandom_range(0, 63) == 0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
